// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Runs one outstanding req/ack bus transaction for loads and stores, aligns and
// extends load data, and registers the write-back bundle.
// Optional macro MEM_MISALIGN_CHECK_EN: misaligned half/word/double accesses raise
// wb_excp and skip the bus; without it wb_excp stays 0 and accesses issue truncated.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_mem_op,
    input  logic [63:0] ex_result,
    input  logic [63:0] ex_store_data,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_rd_wen,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wmask,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_rd_wen,
    output logic [63:0] wb_rd_data,
    output logic        wb_excp
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [2:0]  r_lane;
    logic [4:0]  r_rd_addr;
    logic        r_rd_wen;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [63:0] r_bus_addr;
    logic [63:0] r_bus_wdata;
    logic [7:0]  r_bus_wmask;
    logic        r_wb_valid;
    logic [4:0]  r_wb_rd_addr;
    logic        r_wb_rd_wen;
    logic [63:0] r_wb_rd_data;
    logic        r_wb_excp;

    logic        w_xfer;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misalign;
    logic [1:0]  w_size_ex;
    logic [1:0]  w_size_r;
    logic        w_sign_r;
    logic [7:0]  w_mask_base;
    logic [7:0]  w_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_load_data;

    // Access size: 0=byte, 1=half, 2=word, 3=double.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        return op[3] ? op[1:0] : (op > 4'd4) ? 2'(op - 4'd5) : 2'(op - 4'd1);
    endfunction

    assign ex_ready    = (r_state == IDLE) & ~rst;
    assign w_xfer      = ex_valid & ex_ready;
    assign w_is_load   = (ex_mem_op >= 4'd1) && (ex_mem_op <= 4'd7);
    assign w_is_store  = (ex_mem_op >= 4'd8) && (ex_mem_op <= 4'd11);
    assign w_is_mem    = w_is_load | w_is_store;
    assign w_size_ex   = op_size(ex_mem_op);
    assign w_size_r    = op_size(r_op);
    assign w_sign_r    = r_op <= 4'd3;
    assign w_mask_base = (w_size_ex == 2'd0) ? 8'h01 : (w_size_ex == 2'd1) ? 8'h03 :
                         (w_size_ex == 2'd2) ? 8'h0F : 8'hFF;
    assign w_mask      = w_mask_base << ex_result[2:0];
    assign w_shifted   = bus_rdata >> {r_lane, 3'b000};
    assign w_load_data = (w_size_r == 2'd0) ? {{56{w_sign_r & w_shifted[7]}},  w_shifted[7:0]}  :
                         (w_size_r == 2'd1) ? {{48{w_sign_r & w_shifted[15]}}, w_shifted[15:0]} :
                         (w_size_r == 2'd2) ? {{32{w_sign_r & w_shifted[31]}}, w_shifted[31:0]} :
                         w_shifted;

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = w_is_mem && (((w_size_ex == 2'd1) && ex_result[0]) ||
                                     ((w_size_ex == 2'd2) && (|ex_result[1:0])) ||
                                     ((w_size_ex == 2'd3) && (|ex_result[2:0])));
`else
    assign w_misalign = 1'b0;
`endif

    // FSM: accepts bundles in IDLE, holds the bus request in BUSY until ack, registers write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_op         <= 4'd0;
            r_lane       <= 3'd0;
            r_rd_addr    <= 5'd0;
            r_rd_wen     <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 64'd0;
            r_bus_wdata  <= 64'd0;
            r_bus_wmask  <= 8'd0;
            r_wb_valid   <= 1'b0;
            r_wb_rd_addr <= 5'd0;
            r_wb_rd_wen  <= 1'b0;
            r_wb_rd_data <= 64'd0;
            r_wb_excp    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_xfer && (!w_is_mem || w_misalign)) begin
                    r_wb_valid   <= 1'b1;
                    r_wb_rd_addr <= ex_rd_addr;
                    r_wb_rd_wen  <= ~w_misalign & ex_rd_wen & (|ex_rd_addr);
                    r_wb_rd_data <= ex_result;
                    r_wb_excp    <= w_misalign;
                end else if (w_xfer) begin
                    r_state     <= BUSY;
                    r_op        <= ex_mem_op;
                    r_lane      <= ex_result[2:0];
                    r_rd_addr   <= ex_rd_addr;
                    r_rd_wen    <= w_is_load & ex_rd_wen & (|ex_rd_addr);
                    r_bus_req   <= 1'b1;
                    r_bus_we    <= w_is_store;
                    r_bus_addr  <= {ex_result[63:3], 3'b000};
                    r_bus_wdata <= w_is_store ? ex_store_data << {ex_result[2:0], 3'b000} : 64'd0;
                    r_bus_wmask <= w_mask;
                end
            end else if (bus_ack) begin
                r_state      <= IDLE;
                r_bus_req    <= 1'b0;
                r_wb_valid   <= 1'b1;
                r_wb_rd_addr <= r_rd_addr;
                r_wb_rd_wen  <= r_rd_wen;
                r_wb_rd_data <= r_bus_we ? 64'd0 : w_load_data;
                r_wb_excp    <= 1'b0;
            end
        end
    end

    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_wmask  = r_bus_wmask;
    assign wb_valid   = r_wb_valid;
    assign wb_rd_addr = r_wb_rd_addr;
    assign wb_rd_wen  = r_wb_rd_wen;
    assign wb_rd_data = r_wb_rd_data;
    assign wb_excp    = r_wb_excp;
endmodule
